// File: rtl/reg_dump_pkg.sv
// ============================================================================
// Module   : reg_dump_pkg
// Purpose  : Shared types and constants for the register-file dump block.
//            Holds the dump FSM state type, the default register count and
//            the zero-pad width used to widen the 2-bit status word to 16 bits.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_dump_pkg;

    // Dump FSM states. Values are fixed so that state dumps and waveforms
    // stay readable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

    // Number of registers dumped when the instantiating code does not override it.
    localparam int NREG_DEFAULT = 8;

    // Zero bits placed above the 2-bit status field to fill a 16-bit word.
    localparam int S_WORD_PAD = 14;

    // Width of the word index counter (covers 0..NREG, with NREG up to 15).
    localparam int IDX_W = 4;

endpackage : reg_dump_pkg

`default_nettype wire

// File: rtl/reg_dump.sv
// ============================================================================
// Module   : reg_dump
// Purpose  : Streams the contents of a small register file out through a
//            valid/ready port. A dump reads registers 0..NREG-1 one at a time
//            through a combinational read port. After the last register it
//            emits one status word built from the live status bits. Each word
//            is sampled in its own READ cycle, so the dump is not a coherent
//            snapshot of the whole file.
// Ports    :
//   Clk       in   1   rising-edge clock
//   Reset     in   1   synchronous, active-high reset
//   Start     in   1   dump request, looked at only while idle
//   RdAddr    out  3   register-file read address (non-zero only in READ)
//   RdData    in   W   combinational read data for RdAddr
//   SIn       in   2   live status bits
//   OutData   out  W   dumped word
//   OutIdx    out  4   word index: 0..NREG-1 registers, NREG status word
//   OutValid  out  1   OutData/OutIdx valid
//   OutReady  in   1   consumer accepts the current word
//   Busy      out  1   dump in progress
//   Done      out  1   one-cycle pulse after the final word transfers
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int W    = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    output logic [2:0]           RdAddr,
    input  logic [W-1:0]         RdData,
    input  logic [1:0]           SIn,
    output logic [W-1:0]         OutData,
    output logic [IDX_W-1:0]     OutIdx,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic                 Busy,
    output logic                 Done
);

    // Index of the status word, which is also the last index of a dump.
    localparam logic [IDX_W-1:0] NREG_IDX = IDX_W'(NREG);

    state_e               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [W-1:0]         out_data_q;
    logic [IDX_W-1:0]     out_idx_q;
    logic                 out_valid_q;
    logic                 done_q;

    // Status word: the two status bits, zero-extended to the data width.
    logic [W-1:0]         status_word;
    assign status_word = {{(W-2){1'b0}}, SIn};

    // One process holds the FSM, the index counter and the registered
    // outputs, so that each word's capture and its handshake stay in step.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        idx_q   <= '0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    // RdAddr is driven from idx_q in this state, so RdData
                    // already holds the register for this index.
                    out_data_q  <= (idx_q < NREG_IDX) ? RdData : status_word;
                    out_idx_q   <= idx_q;
                    out_valid_q <= 1'b1;
                    state_q     <= SEND;
                end
                SEND: begin
                    // out_valid_q is always set in SEND, so OutReady alone
                    // marks the transfer.
                    if (OutReady) begin
                        out_valid_q <= 1'b0;
                        if (idx_q == NREG_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= READ;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The read address is held at zero outside READ so that the register
    // file sees a quiet address bus between reads.
    always_comb begin
        RdAddr = 3'd0;
        Busy   = 1'b0;
        if (state_q == READ) begin
            RdAddr = idx_q[2:0];
        end
        if (state_q != IDLE) begin
            Busy = 1'b1;
        end
    end

    assign OutData  = out_data_q;
    assign OutIdx   = out_idx_q;
    assign OutValid = out_valid_q;
    assign Done     = done_q;

endmodule : reg_dump

`default_nettype wire

// File: tb/tb_reg_dump.sv
// ============================================================================
// Module   : tb_reg_dump
// Purpose  : Self-checking bench for reg_dump. Stimulus pushes the expected
//            {index, data} words into a queue. A monitor pops and compares
//            each word that transfers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_dump;

    localparam int NREG = 8;
    localparam int W    = 16;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic [2:0]    RdAddr;
    logic [W-1:0]  RdData;
    logic [1:0]    SIn;
    logic [W-1:0]  OutData;
    logic [3:0]    OutIdx;
    logic          OutValid;
    logic          OutReady;
    logic          Busy;
    logic          Done;

    logic [W-1:0]  regs [NREG];
    logic [19:0]   sb_q [$];

    int total;
    int bad;
    int done_cnt;

    assign RdData = regs[RdAddr];

    reg_dump #(.NREG(NREG), .W(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .RdAddr   (RdAddr),
        .RdData   (RdData),
        .SIn      (SIn),
        .OutData  (OutData),
        .OutIdx   (OutIdx),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: a word transfers when valid and ready are both high and
    // reset is not pending on the coming edge.
    always @(negedge Clk) begin
        if (Done === 1'b1) done_cnt++;
        if (OutValid === 1'b1 && OutReady === 1'b1 && Reset === 1'b0) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL word_unexpected: got idx=%0d data=0x%0h expected none",
                         OutIdx, OutData);
            end else begin
                check("word", {12'd0, OutIdx, OutData}, {12'd0, sb_q.pop_front()});
            end
        end
    end

    // Queue the expected words of a dump, starting at index first.
    task automatic push_words(input int first, input int last, input logic [15:0] r6,
                              input logic [1:0] s);
        for (int i = first; i <= last; i++) begin
            if (i == NREG)      sb_q.push_back({4'(i), 14'd0, s});
            else if (i == 6)    sb_q.push_back({4'(i), r6});
            else                sb_q.push_back({4'(i), 16'h1000 + 16'(i)});
        end
    endtask

    // Pulse Start and count edges until Done. Called and returns at posedge+1.
    task automatic run_dump(input int exp_cycles, input bit exp_done, input string tag);
        int  n;
        int  first_v;
        bit  seen_done;
        n = 0;
        first_v = -1;
        seen_done = 1'b0;
        Start = 1'b1;
        while (n < 60) begin
            @(posedge Clk);
            #1;
            n++;
            if (n == 1) Start = 1'b0;
            if (OutValid === 1'b1 && first_v < 0) first_v = n;
            if (Done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
        end
        if (exp_done) begin
            check({tag, "_start_to_done"}, 32'(n), 32'(exp_cycles));
            check({tag, "_first_valid_lat"}, 32'(first_v), 32'd2);
            @(posedge Clk);
            #1;
            check({tag, "_done_one_cycle"}, {31'd0, Done}, 32'd0);
            check({tag, "_idle_after"}, {31'd0, Busy}, 32'd0);
        end else begin
            check({tag, "_no_done"}, {31'd0, seen_done}, 32'd0);
        end
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        Reset    = 1'b1;
        Start    = 1'b0;
        SIn      = 2'b10;
        OutReady = 1'b1;
        for (int i = 0; i < NREG; i++) regs[i] = 16'h1000 + 16'(i);

        // ---- reset state ----
        repeat (3) @(posedge Clk);
        #1;
        check("rst_outvalid", {31'd0, OutValid}, 32'd0);
        check("rst_busy",     {31'd0, Busy},     32'd0);
        check("rst_done",     {31'd0, Done},     32'd0);
        check("rst_rdaddr",   {29'd0, RdAddr},   32'd0);
        check("rst_outdata",  {16'd0, OutData},  32'd0);
        check("rst_outidx",   {28'd0, OutIdx},   32'd0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // ---- basic dump ----
        done_cnt = 0;
        push_words(0, NREG, 16'h1006, 2'b10);
        run_dump(19, 1'b1, "basic");
        check("basic_done_count", 32'(done_cnt), 32'd1);

        // ---- backpressure on word 3 ----
        done_cnt = 0;
        push_words(0, NREG, 16'h1006, 2'b10);
        fork
            run_dump(24, 1'b1, "bp");
            begin
                int k;
                k = 0;
                while (!(OutValid === 1'b1 && OutIdx == 4'd3) && k < 40) begin
                    @(posedge Clk);
                    #1;
                    k++;
                end
                OutReady = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge Clk);
                    check("bp_hold_data",  {16'd0, OutData},  32'h1003);
                    check("bp_hold_idx",   {28'd0, OutIdx},   32'd3);
                    check("bp_hold_valid", {31'd0, OutValid}, 32'd1);
                    @(posedge Clk);
                end
                #1;
                OutReady = 1'b1;
            end
        join
        check("bp_done_count", 32'(done_cnt), 32'd1);

        // ---- Start while busy and during DONE ----
        done_cnt = 0;
        push_words(0, NREG, 16'h1006, 2'b10);
        fork
            run_dump(19, 1'b1, "busy");
            begin
                int k;
                k = 0;
                while (!(OutValid === 1'b1 && OutIdx == 4'd4) && k < 40) begin
                    @(posedge Clk);
                    #1;
                    k++;
                end
                Start = 1'b1;
                @(posedge Clk);
                #1;
                Start = 1'b0;
                k = 0;
                while (Done !== 1'b1 && k < 40) begin
                    @(posedge Clk);
                    #1;
                    k++;
                end
                Start = 1'b1;
                @(posedge Clk);
                #1;
                Start = 1'b0;
                check("busy_done_start_busy", {31'd0, Busy}, 32'd0);
                @(posedge Clk);
                #1;
                check("busy_done_start_busy2", {31'd0, Busy}, 32'd0);
            end
        join
        check("busy_done_count", 32'(done_cnt), 32'd1);

        // ---- reset while index 5 is offered ----
        done_cnt = 0;
        push_words(0, 4, 16'h1006, 2'b10);
        fork
            run_dump(0, 1'b0, "rstmid");
            begin
                int k;
                k = 0;
                while (!(OutValid === 1'b1 && OutIdx == 4'd5) && k < 40) begin
                    @(posedge Clk);
                    #1;
                    k++;
                end
                Reset = 1'b1;
                @(posedge Clk);
                #1;
                Reset = 1'b0;
                check("rstmid_outvalid", {31'd0, OutValid}, 32'd0);
                check("rstmid_busy",     {31'd0, Busy},     32'd0);
            end
        join
        check("rstmid_done_count", 32'(done_cnt), 32'd0);

        // ---- restart after abort begins at index 0 ----
        done_cnt = 0;
        push_words(0, NREG, 16'h1006, 2'b10);
        run_dump(19, 1'b1, "restart");

        // ---- live write of register 6 mid-dump, different status bits ----
        done_cnt = 0;
        SIn = 2'b01;
        push_words(0, NREG, 16'hBEEF, 2'b01);
        fork
            run_dump(19, 1'b1, "live");
            begin
                repeat (2) @(posedge Clk);
                #1;
                regs[6] = 16'hBEEF;
            end
        join
        check("live_done_count", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_dump

`default_nettype wire
